mp_add_ctrl: RTL and testbench

MP_ADD_CTRL -- requirements
Module: mp_add_ctrl

---
 rtl/mp_add_ctrl_pkg.sv | 19 +
 rtl/full_adder_64bit.sv | 15 +
 rtl/mp_add_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mp_add_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp_add_ctrl_pkg.sv
// Shared constants and FSM state type for the word-serial multi-precision adder.
// Used by mp_add_ctrl (optional MP_ADD_CTRL_OVERFLOW_EN) and full_adder_64bit.
package mp_add_ctrl_pkg;

  localparam int WORD_W    = 64;
  localparam int MAX_WORDS = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Index register width; a single-word build still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/full_adder_64bit.sv
// Single 64-bit adder with carry-in and carry-out.
// The controller time-multiplexes this one instance across all operand words.
module full_adder_64bit
  import mp_add_ctrl_pkg::*;
(
  input  logic [WORD_W-1:0] a_i,
  input  logic [WORD_W-1:0] b_i,
  input  logic              c_i,
  output logic [WORD_W-1:0] sum_o,
  output logic              c_o
);

  assign {c_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{WORD_W{1'b0}}, c_i};

endmodule

// File: rtl/mp_add_ctrl.sv
// Word-serial add/subtract controller: one 64-bit word per RUN cycle, LSW first.
// Define MP_ADD_CTRL_OVERFLOW_EN to add the resp_overflow (signed overflow) output.
//
// state   | meaning
// IDLE    | req_ready high, waiting for a request
// RUN     | one word per cycle through the shared adder
// DONE    | result held; resp_valid from the second DONE cycle until taken
module mp_add_ctrl
  import mp_add_ctrl_pkg::*;
#(
  parameter int WORDS = 4
)
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_sub,
  input  logic [WORD_W*WORDS-1:0] req_a,
  input  logic [WORD_W*WORDS-1:0] req_b,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [WORD_W*WORDS-1:0] resp_sum,
  output logic                    resp_carry,
  output logic                    busy
`ifdef MP_ADD_CTRL_OVERFLOW_EN
  ,
  output logic                    resp_overflow
`endif
);

  localparam int OP_W  = WORD_W * WORDS;
  localparam int IDX_W = idx_width(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              carry_q, carry_d;
  logic              valid_q, valid_d;
  logic [OP_W-1:0]   a_q, b_q;
  logic [OP_W-1:0]   sum_q;
  logic              load, step, step_last;

  logic [WORD_W-1:0] a_word, b_word, add_sum;
  logic              add_cout;

  always_comb begin
    a_word = '0;
    b_word = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_word = a_q[i*WORD_W +: WORD_W];
        b_word = b_q[i*WORD_W +: WORD_W];
      end
    end
  end

  full_adder_64bit u_adder (
    .a_i   (a_word),
    .b_i   (b_word),
    .c_i   (carry_q),
    .sum_o (add_sum),
    .c_o   (add_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    valid_d = valid_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          load    = 1'b1;
          carry_d = req_sub;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        step    = 1'b1;
        carry_d = add_cout;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        // First DONE cycle only settles the full-width result before presenting it.
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (resp_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  assign step_last = step && (idx_q == LAST_IDX);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
      if (step) begin
        for (int i = 0; i < WORDS; i++) begin
          if (idx_q == IDX_W'(i)) begin
            sum_q[i*WORD_W +: WORD_W] <= add_sum;
          end
        end
      end
    end
  end

  // Operands need no reset: they are always loaded before being consumed.
  always_ff @(posedge clock) begin
    if (load) begin
      a_q <= req_a;
      b_q <= req_sub ? ~req_b : req_b;
    end
  end

`ifdef MP_ADD_CTRL_OVERFLOW_EN
  logic ovf_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (step_last) begin
      ovf_q <= (a_word[WORD_W-1] == b_word[WORD_W-1]) &&
               (add_sum[WORD_W-1] != a_word[WORD_W-1]);
    end
  end

  assign resp_overflow = ovf_q;
`else
  logic unused_step_last;
  assign unused_step_last = step_last;
`endif

  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign resp_valid = valid_q;
  assign resp_sum   = sum_q;
  assign resp_carry = carry_q;

endmodule

// File: tb/tb_mp_add_ctrl.sv
// Self-checking bench for mp_add_ctrl (WORDS=4) against an arithmetic reference model.
// Overflow checks are included when MP_ADD_CTRL_OVERFLOW_EN is defined.
module tb_mp_add_ctrl;
  import mp_add_ctrl_pkg::*;

  localparam int WORDS = 4;
  localparam int N     = WORD_W * WORDS;
  localparam int LAT   = WORDS + 1;

  logic         clock = 1'b0;
  logic         reset;
  logic         req_valid, req_ready, req_sub;
  logic [N-1:0] req_a, req_b, resp_sum;
  logic         resp_valid, resp_ready, resp_carry, busy;
`ifdef MP_ADD_CTRL_OVERFLOW_EN
  logic         resp_overflow;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mp_add_ctrl #(.WORDS(WORDS)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_sub    (req_sub),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_sum   (resp_sum),
    .resp_carry (resp_carry),
    .busy       (busy)
`ifdef MP_ADD_CTRL_OVERFLOW_EN
    ,
    .resp_overflow (resp_overflow)
`endif
  );

  // Reference model: plain wide arithmetic, carry = no borrow for subtract.
  function automatic logic [N:0] ref_result(input logic [N-1:0] a, input logic [N-1:0] b,
                                            input logic sub);
    logic [N-1:0] d;
    if (sub) begin
      d = a - b;
      return {(a >= b) ? 1'b1 : 1'b0, d};
    end
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic logic ref_ovf(input logic [N-1:0] a, input logic [N-1:0] b,
                                   input logic sub);
    logic signed [N+1:0] sa, sb, r;
    sa = {{2{a[N-1]}}, a};
    sb = {{2{b[N-1]}}, b};
    r  = sub ? (sa - sb) : (sa + sb);
    return r[N] != r[N-1];
  endfunction

  function automatic logic [N-1:0] rnd_op();
    logic [N-1:0] v;
    for (int i = 0; i < N / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub,
                      output bit ok);
    int n;
    n = 0;
    while (!req_ready && n < 100) begin
      tick();
      n++;
    end
    req_a     = a;
    req_b     = b;
    req_sub   = sub;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    ok = (n < 100);
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    while (!resp_valid && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  task automatic take();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic xact(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub,
                      input int delay, output logic [N-1:0] s, output logic c,
                      output logic o, output int lat);
    bit ok;
    send(a, b, sub, ok);
    if (!ok) lat = 999;
    else wait_resp(lat);
    repeat (delay) tick();
    s = resp_sum;
    c = resp_carry;
`ifdef MP_ADD_CTRL_OVERFLOW_EN
    o = resp_overflow;
`else
    o = 1'b0;
`endif
    if (resp_valid) take();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (resp_sum !== '0) begin errors++; $display("FAIL reset_sum got %h exp 0", resp_sum); end
    checks++; if (resp_carry !== 1'b0) begin errors++; $display("FAIL reset_carry got %b exp 0", resp_carry); end
`ifdef MP_ADD_CTRL_OVERFLOW_EN
    checks++; if (resp_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", resp_overflow); end
`endif
  endtask

  task automatic test_add_carry();
    logic [N-1:0] s;
    logic c, o;
    int lat;
    xact({N{1'b1}}, N'(1), 1'b0, 0, s, c, o, lat);
    checks++; if (s !== '0) begin errors++; $display("FAIL add_wrap_sum got %h exp 0", s); end
    checks++; if (c !== 1'b1) begin errors++; $display("FAIL add_wrap_carry got %b exp 1", c); end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL add_latency got %0d exp %0d", lat, LAT); end
  endtask

  task automatic test_sub();
    logic [N-1:0] s;
    logic c, o;
    int lat;
    xact('0, N'(1), 1'b1, 0, s, c, o, lat);
    checks++; if (s !== {N{1'b1}}) begin errors++; $display("FAIL sub_borrow_sum got %h exp all-ones", s); end
    checks++; if (c !== 1'b0) begin errors++; $display("FAIL sub_borrow_carry got %b exp 0", c); end
    xact(N'(5), N'(3), 1'b1, 1, s, c, o, lat);
    checks++; if (s !== N'(2)) begin errors++; $display("FAIL sub_5_3_sum got %h exp 2", s); end
    checks++; if (c !== 1'b1) begin errors++; $display("FAIL sub_5_3_carry got %b exp 1", c); end
  endtask

  task automatic test_random();
    logic [N-1:0] a, b, s;
    logic [N:0]   e;
    logic sub, c, o, eo;
    int lat, kind;
    for (int k = 0; k < 24; k++) begin
      sub  = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 3);
      a = rnd_op();
      b = rnd_op();
      if (kind == 1) a = {N{1'b1}};
      if (kind == 2) b = '0;
      if (kind == 3) b = a;
      e  = ref_result(a, b, sub);
      eo = ref_ovf(a, b, sub);
      xact(a, b, sub, $urandom_range(0, 3), s, c, o, lat);
      checks++; if (s !== e[N-1:0]) begin errors++; $display("FAIL rand%0d_sum got %h exp %h", k, s, e[N-1:0]); end
      checks++; if (c !== e[N]) begin errors++; $display("FAIL rand%0d_carry got %b exp %b", k, c, e[N]); end
      checks++; if (lat !== LAT) begin errors++; $display("FAIL rand%0d_latency got %0d exp %0d", k, lat, LAT); end
`ifdef MP_ADD_CTRL_OVERFLOW_EN
      checks++; if (o !== eo) begin errors++; $display("FAIL rand%0d_ovf got %b exp %b", k, o, eo); end
`else
      if (o !== 1'b0 || eo === 1'bx) ;
`endif
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] a, b;
    logic [N:0]   e;
    bit ok;
    int lat;
    a = rnd_op();
    b = rnd_op();
    e = ref_result(a, b, 1'b0);
    send(a, b, 1'b0, ok);
    wait_resp(lat);
    checks++; if (!ok || lat !== LAT) begin errors++; $display("FAIL bp_latency got %0d exp %0d", lat, LAT); end
    for (int i = 0; i < 10; i++) begin
      req_a = rnd_op();
      req_b = rnd_op();
      req_sub = 1'b1;
      req_valid = 1'b1;
      tick();
      checks++; if (resp_sum !== e[N-1:0]) begin errors++; $display("FAIL bp%0d_sum got %h exp %h", i, resp_sum, e[N-1:0]); end
      checks++; if (resp_carry !== e[N]) begin errors++; $display("FAIL bp%0d_carry got %b exp %b", i, resp_carry, e[N]); end
      checks++; if (req_ready !== 1'b0 || resp_valid !== 1'b1) begin errors++; $display("FAIL bp%0d_hs got ready %b valid %b exp 0 1", i, req_ready, resp_valid); end
    end
    req_valid = 1'b0;
    take();
    checks++; if (busy !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_release got busy %b ready %b exp 0 1", busy, req_ready); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_ignored_req got busy %b exp 0", busy); end
  endtask

  task automatic test_reset_mid_run();
    logic [N-1:0] s;
    logic c, o;
    bit ok;
    int lat;
    send(rnd_op(), rnd_op(), 1'b0, ok);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL midrun_reset got valid %b busy %b ready %b exp 0 0 1", resp_valid, busy, req_ready); end
    repeat (WORDS + 2) tick();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL midrun_no_resp got %b exp 0", resp_valid); end
    xact(N'(3), N'(4), 1'b0, 0, s, c, o, lat);
    checks++; if (s !== N'(7) || c !== 1'b0) begin errors++; $display("FAIL midrun_3p4 got %h c %b exp 7 c 0", s, c); end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] a1, b1, a2, b2;
    logic [N:0]   e1, e2;
    int lat;
    a1 = rnd_op(); b1 = rnd_op();
    a2 = rnd_op(); b2 = rnd_op();
    e1 = ref_result(a1, b1, 1'b0);
    e2 = ref_result(a2, b2, 1'b1);
    req_a = a1; req_b = b1; req_sub = 1'b0; req_valid = 1'b1;
    tick();
    req_a = a2; req_b = b2; req_sub = 1'b1;
    wait_resp(lat);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL b2b_lat1 got %0d exp %0d", lat, LAT); end
    checks++; if (resp_sum !== e1[N-1:0] || resp_carry !== e1[N]) begin errors++; $display("FAIL b2b_res1 got %h c %b exp %h c %b", resp_sum, resp_carry, e1[N-1:0], e1[N]); end
    take();
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_turnaround got ready %b valid %b exp 1 0", req_ready, resp_valid); end
    tick();
    req_valid = 1'b0;
    checks++; if (busy !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept2 got busy %b ready %b exp 1 0", busy, req_ready); end
    wait_resp(lat);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL b2b_lat2 got %0d exp %0d", lat, LAT); end
    checks++; if (resp_sum !== e2[N-1:0] || resp_carry !== e2[N]) begin errors++; $display("FAIL b2b_res2 got %h c %b exp %h c %b", resp_sum, resp_carry, e2[N-1:0], e2[N]); end
    take();
  endtask

`ifdef MP_ADD_CTRL_OVERFLOW_EN
  task automatic test_overflow();
    logic [N-1:0] s;
    logic c, o;
    int lat;
    xact({1'b0, {(N-1){1'b1}}}, N'(1), 1'b0, 0, s, c, o, lat);
    checks++; if (o !== 1'b1 || c !== 1'b0) begin errors++; $display("FAIL ovf_maxpos got ovf %b c %b exp 1 0", o, c); end
    xact(N'(1), N'(1), 1'b0, 0, s, c, o, lat);
    checks++; if (o !== 1'b0 || s !== N'(2)) begin errors++; $display("FAIL ovf_one_one got ovf %b sum %h exp 0 2", o, s); end
  endtask
`endif

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_sub    = 1'b0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    test_reset();
    test_add_carry();
    test_sub();
    test_random();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
`ifdef MP_ADD_CTRL_OVERFLOW_EN
    test_overflow();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
